hangman_host_engine: RTL and testbench

Parametrised host-side game engine for wireless hangman. Accepts guessed letters from the UART receive path through a valid/ready handshake, scans them against a latched secret word of configurable length, and tracks hits, mistakes, repeated guesses and win/lose. Returns a one-byte verdict to the UART transmit path and drives the host display with per-letter reveal status. It replaces the fixed 5-letter, fixed-mistake game logic between the receive buffer and the host display/transmitter.

---
 rtl/hangman_pkg.sv | 36 +++
 rtl/letter_scan.sv | 60 ++++++
 rtl/hangman_host_engine.sv | 199 +++++++++++++++++++
 tb/tb_hangman_host_engine.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared types and helpers for the hangman host engine.
//   state_e      : engine FSM states
//   V_*          : one-byte verdict codes returned to the UART transmitter
//   norm_letter  : folds 'a'..'z' to uppercase, other bytes pass through
//   is_letter    : true for 'A'..'Z' (apply after norm_letter)
package hangman_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StCheck,
        StReport,
        StDone
    } state_e;

    localparam logic [7:0] V_HIT  = 8'h48;  // 'H'
    localparam logic [7:0] V_MISS = 8'h4D;  // 'M'
    localparam logic [7:0] V_DUP  = 8'h44;  // 'D'
    localparam logic [7:0] V_INV  = 8'h58;  // 'X'
    localparam logic [7:0] V_WIN  = 8'h57;  // 'W'
    localparam logic [7:0] V_LOSE = 8'h4C;  // 'L'

    function automatic logic [7:0] norm_letter(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b >= 8'h61 && b <= 8'h7A) begin
            r = b - 8'h20;
        end
        return r;
    endfunction

    function automatic logic is_letter(input logic [7:0] b);
        return (b >= 8'h41) && (b <= 8'h5A);
    endfunction

endpackage

// File: rtl/letter_scan.sv
// Walks the secret word one letter per cycle comparing each (case-folded) letter with
// the guess.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : begin a scan at index 0 (clears the hit flag)
//   abort_i        : cancel a scan in progress
//   guess_i        : normalised guess byte, held stable during the scan
//   word_i         : secret word, letter 0 in bits [7:0]
//   match_vec_o    : one-hot of the index matched this cycle (all zero on no match)
//   hit_o          : any match so far in this scan, including the current index
//   done_o         : high in the cycle the last index is compared
module letter_scan import hangman_pkg::*; #(
    parameter int unsigned WORD_LEN = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [7:0]            guess_i,
    input  logic [8*WORD_LEN-1:0] word_i,
    output logic [WORD_LEN-1:0]   match_vec_o,
    output logic                  hit_o,
    output logic                  done_o
);

    localparam int unsigned IdxW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    logic            active_q;
    logic [IdxW-1:0] idx_q;
    logic            hit_q;
    logic            match;

    always_comb begin
        match  = active_q && (norm_letter(word_i[idx_q*8 +: 8]) == guess_i);
        done_o = active_q && (idx_q == IdxW'(WORD_LEN - 1));
        hit_o  = hit_q | match;
        for (int i = 0; i < WORD_LEN; i++) begin
            match_vec_o[i] = match && (idx_q == IdxW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
        end else if (start_i) begin
            active_q <= 1'b1;
            idx_q    <= '0;
            hit_q    <= 1'b0;
        end else if (active_q) begin
            hit_q <= hit_q | match;
            if (done_o) begin
                active_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hangman_host_engine.sv
// Host-side hangman game engine: accepts guesses over a valid/ready handshake, scans
// them against the latched word, tracks hits/misses/win/lose and returns a verdict byte.
// Optional feature: define HANGMAN_DUP_DETECT_EN to report repeated letters as 'D'.
//   clk_i          : system clock
//   nrst_i         : synchronous reset, active-high despite the name
//   start_i        : latch set_word_i and begin a new game (beats any handshake)
//   set_word_i     : secret word, letter 0 in bits [7:0]
//   rx_valid_i/rx_byte_i/rx_ready_o : guess input handshake
//   tx_valid_o/tx_byte_o/tx_ready_i : verdict output handshake
//   hit_mask_o     : revealed letters; miss_cnt_o: mistakes; last_letter_o: last guess
//   busy_o         : scanning or reporting; won_o/lost_o: held game-over flags
module hangman_host_engine import hangman_pkg::*; #(
    parameter int unsigned WORD_LEN     = 5,
    parameter int unsigned MAX_MISTAKES = 6
) (
    input  logic                  clk_i,
    input  logic                  nrst_i,
    input  logic                  start_i,
    input  logic [8*WORD_LEN-1:0] set_word_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_byte_i,
    output logic                  rx_ready_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_byte_o,
    input  logic                  tx_ready_i,
    output logic [WORD_LEN-1:0]   hit_mask_o,
    output logic [3:0]            miss_cnt_o,
    output logic [7:0]            last_letter_o,
    output logic                  busy_o,
    output logic                  won_o,
    output logic                  lost_o
);

    state_e                state_q, state_d;
    logic [8*WORD_LEN-1:0] word_q, word_d;
    logic [7:0]            guess_q, guess_d;
    logic [WORD_LEN-1:0]   mask_q, mask_d;
    logic [3:0]            miss_q, miss_d;
    logic [7:0]            verdict_q, verdict_d;
    logic                  won_q, won_d;
    logic                  lost_q, lost_d;

    logic                  scan_start;
    logic [WORD_LEN-1:0]   scan_vec;
    logic                  scan_hit;
    logic                  scan_done;
    logic [7:0]            rx_norm;
    logic [WORD_LEN-1:0]   mask_new;
    logic [3:0]            miss_inc;

`ifdef HANGMAN_DUP_DETECT_EN
    logic [25:0] bitmap_q, bitmap_d;
    logic        dup_q, dup_d;
    logic [4:0]  rx_idx;
    logic [4:0]  guess_idx;
    assign rx_idx    = 5'(rx_norm - 8'h41);
    assign guess_idx = 5'(guess_q - 8'h41);
`else
    logic        dup_q;
    assign dup_q = 1'b0;
`endif

    letter_scan #(
        .WORD_LEN (WORD_LEN)
    ) u_scan (
        .clk_i       (clk_i),
        .rst_i       (nrst_i),
        .start_i     (scan_start),
        .abort_i     (start_i),
        .guess_i     (guess_q),
        .word_i      (word_q),
        .match_vec_o (scan_vec),
        .hit_o       (scan_hit),
        .done_o      (scan_done)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        guess_d    = guess_q;
        mask_d     = mask_q;
        miss_d     = miss_q;
        verdict_d  = verdict_q;
        won_d      = won_q;
        lost_d     = lost_q;
        scan_start = 1'b0;
        rx_norm    = norm_letter(rx_byte_i);
        mask_new   = mask_q | scan_vec;
        miss_inc   = (miss_q >= 4'(MAX_MISTAKES)) ? miss_q : miss_q + 4'd1;
`ifdef HANGMAN_DUP_DETECT_EN
        bitmap_d   = bitmap_q;
        dup_d      = dup_q;
`endif
        if (start_i) begin
            // Restart from any state; a pending verdict is dropped.
            state_d = StPlay;
            word_d  = set_word_i;
            mask_d  = '0;
            miss_d  = '0;
            won_d   = 1'b0;
            lost_d  = 1'b0;
`ifdef HANGMAN_DUP_DETECT_EN
            bitmap_d = '0;
`endif
        end else begin
            unique case (state_q)
                StPlay: begin
                    if (rx_valid_i) begin
                        guess_d = rx_norm;
                        if (is_letter(rx_norm)) begin
                            state_d    = StCheck;
                            scan_start = 1'b1;
`ifdef HANGMAN_DUP_DETECT_EN
                            dup_d = bitmap_q[rx_idx];
`endif
                        end else begin
                            verdict_d = V_INV;
                            state_d   = StReport;
                        end
                    end
                end
                StCheck: begin
                    if (!dup_q) begin
                        mask_d = mask_new;
                    end
                    if (scan_done) begin
                        state_d = StReport;
`ifdef HANGMAN_DUP_DETECT_EN
                        bitmap_d[guess_idx] = 1'b1;
`endif
                        if (dup_q) begin
                            verdict_d = V_DUP;
                        end else if (scan_hit) begin
                            verdict_d = (&mask_new) ? V_WIN : V_HIT;
                        end else begin
                            miss_d    = miss_inc;
                            verdict_d = (miss_inc == 4'(MAX_MISTAKES)) ? V_LOSE : V_MISS;
                        end
                    end
                end
                StReport: begin
                    if (tx_ready_i) begin
                        if (verdict_q == V_WIN) begin
                            won_d   = 1'b1;
                            state_d = StDone;
                        end else if (verdict_q == V_LOSE) begin
                            lost_d  = 1'b1;
                            state_d = StDone;
                        end else begin
                            state_d = StPlay;
                        end
                    end
                end
                default: ;  // StIdle and StDone wait for start_i
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (nrst_i) begin
            state_q   <= StIdle;
            word_q    <= '0;
            guess_q   <= '0;
            mask_q    <= '0;
            miss_q    <= '0;
            verdict_q <= '0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
`ifdef HANGMAN_DUP_DETECT_EN
            bitmap_q  <= '0;
            dup_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            guess_q   <= guess_d;
            mask_q    <= mask_d;
            miss_q    <= miss_d;
            verdict_q <= verdict_d;
            won_q     <= won_d;
            lost_q    <= lost_d;
`ifdef HANGMAN_DUP_DETECT_EN
            bitmap_q  <= bitmap_d;
            dup_q     <= dup_d;
`endif
        end
    end

    assign rx_ready_o    = (state_q == StPlay);
    assign tx_valid_o    = (state_q == StReport);
    assign tx_byte_o     = verdict_q;
    assign hit_mask_o    = mask_q;
    assign miss_cnt_o    = miss_q;
    assign last_letter_o = guess_q;
    assign busy_o        = (state_q == StCheck) || (state_q == StReport);
    assign won_o         = won_q;
    assign lost_o        = lost_q;

endmodule

// File: tb/tb_hangman_host_engine.sv
// Self-checking bench for hangman_host_engine: directed scenarios plus randomized games
// checked against a letter-level reference model of the game rules.
module tb_hangman_host_engine;

    localparam int WL = 5;
    localparam int MM = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [8*WL-1:0] set_word;
    logic            rx_valid;
    logic [7:0]      rx_byte;
    logic            rx_ready;
    logic            tx_valid;
    logic [7:0]      tx_byte;
    logic            tx_ready;
    logic [WL-1:0]   hit_mask;
    logic [3:0]      miss_cnt;
    logic [7:0]      last_letter;
    logic            busy;
    logic            won;
    logic            lost;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: the word as letters, which positions are revealed,
    // the miss count, the set of letters already tried and the game outcome.
    logic [7:0] m_word [WL];
    bit         m_rev  [WL];
    bit         m_seen [26];
    int         m_miss;
    logic [7:0] m_last;
    bit         m_won;
    bit         m_lost;

    always #5 clk = ~clk;

    hangman_host_engine #(
        .WORD_LEN     (WL),
        .MAX_MISTAKES (MM)
    ) dut (
        .clk_i         (clk),
        .nrst_i        (rst),
        .start_i       (start),
        .set_word_i    (set_word),
        .rx_valid_i    (rx_valid),
        .rx_byte_i     (rx_byte),
        .rx_ready_o    (rx_ready),
        .tx_valid_o    (tx_valid),
        .tx_byte_o     (tx_byte),
        .tx_ready_i    (tx_ready),
        .hit_mask_o    (hit_mask),
        .miss_cnt_o    (miss_cnt),
        .last_letter_o (last_letter),
        .busy_o        (busy),
        .won_o         (won),
        .lost_o        (lost)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_norm(input logic [7:0] b);
        if (b >= "a" && b <= "z") return b - 8'd32;
        return b;
    endfunction

    function automatic logic [8*WL-1:0] pack_word(input string s);
        logic [8*WL-1:0] r;
        for (int i = 0; i < WL; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [WL-1:0] m_mask();
        logic [WL-1:0] r;
        for (int i = 0; i < WL; i++) r[i] = m_rev[i];
        return r;
    endfunction

    task automatic new_game(input logic [8*WL-1:0] w);
        set_word = w;
        start    = 1'b1;
        step();
        start    = 1'b0;
        for (int i = 0; i < WL; i++) begin
            m_word[i] = w[8*i +: 8];
            m_rev[i]  = 1'b0;
        end
        for (int i = 0; i < 26; i++) m_seen[i] = 1'b0;
        m_miss = 0;
        m_won  = 1'b0;
        m_lost = 1'b0;
    endtask

    task automatic model_guess(input logic [7:0] b, output logic [7:0] v);
        logic [7:0] g;
        bit         hit;
        bit         all;
        g      = m_norm(b);
        m_last = g;
        hit    = 1'b0;
        if (g < "A" || g > "Z") begin
            v = "X";
            return;
        end
`ifdef HANGMAN_DUP_DETECT_EN
        if (m_seen[int'(g) - 65]) begin
            v = "D";
            return;
        end
`endif
        m_seen[int'(g) - 65] = 1'b1;
        for (int i = 0; i < WL; i++) begin
            if (m_norm(m_word[i]) == g) begin
                m_rev[i] = 1'b1;
                hit      = 1'b1;
            end
        end
        if (hit) begin
            all = 1'b1;
            for (int i = 0; i < WL; i++) if (!m_rev[i]) all = 1'b0;
            v     = all ? "W" : "H";
            m_won = all;
        end else begin
            m_miss++;
            if (m_miss == MM) begin
                v      = "L";
                m_lost = 1'b1;
            end else begin
                v = "M";
            end
        end
    endtask

    // Offers one guess, waits for the verdict and acknowledges it at once.
    // lat counts cycles from acceptance to the first cycle tx_valid is seen high.
    task automatic do_guess(input logic [7:0] b, output logic [7:0] v, output int lat);
        int n;
        n = 0;
        while (!rx_ready && n < 50) begin
            step();
            n++;
        end
        if (!rx_ready) begin
            n_total++;
            $display("FAIL guess_accept: rx_ready=%b required 1", rx_ready);
            v   = 8'h00;
            lat = -1;
            return;
        end
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
        lat      = 1;
        while (!tx_valid && lat < 100) begin
            step();
            lat++;
        end
        v        = tx_valid ? tx_byte : 8'h00;
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;  // reset must win over start
        set_word = pack_word("APPLE");
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tx_ready = 1'b0;
        step();
        step();
        n_total++;
        if ({rx_ready, tx_valid, busy, won, lost} !== 5'b0) begin
            $display("FAIL reset_flags: rdy/txv/busy/won/lost=%b required 00000",
                     {rx_ready, tx_valid, busy, won, lost});
        end else n_pass++;
        n_total++;
        if ({tx_byte, last_letter, miss_cnt, hit_mask} !== '0) begin
            $display("FAIL reset_data: tx_byte=%h last=%h miss=%0d mask=%b required zeros",
                     tx_byte, last_letter, miss_cnt, hit_mask);
        end else n_pass++;
        rst   = 1'b0;
        start = 1'b0;
        step();
        n_total++;
        if (rx_ready !== 1'b0) begin
            $display("FAIL reset_idle: rx_ready=%b required 0", rx_ready);
        end else n_pass++;
    endtask

    task automatic test_hit();
        logic [7:0] v;
        int         lat;
        new_game(pack_word("APPLE"));
        do_guess("p", v, lat);
        n_total++;
        if (v !== "H") $display("FAIL hit_verdict: got %h required %h", v, 8'h48);
        else n_pass++;
        n_total++;
        if (lat !== WL + 1) $display("FAIL hit_latency: got %0d required %0d", lat, WL + 1);
        else n_pass++;
        n_total++;
        if (hit_mask !== 5'b00110) $display("FAIL hit_mask: got %b required 00110", hit_mask);
        else n_pass++;
        n_total++;
        if (last_letter !== "P") $display("FAIL hit_last: got %h required %h", last_letter, 8'h50);
        else n_pass++;
    endtask

    task automatic test_lose();
        logic [7:0] v;
        int         lat;
        string      gs;
        string      exp;
        gs  = "ZQXJKV";
        exp = "MMMMML";
        new_game(pack_word("APPLE"));
        for (int i = 0; i < 6; i++) begin
            do_guess(gs[i], v, lat);
            n_total++;
            if (v !== exp[i]) $display("FAIL lose_verdict%0d: got %h required %h", i, v, exp[i]);
            else n_pass++;
        end
        n_total++;
        if ({lost, won, rx_ready} !== 3'b100) begin
            $display("FAIL lose_flags: lost/won/rdy=%b required 100", {lost, won, rx_ready});
        end else n_pass++;
        rx_valid = 1'b1;
        rx_byte  = "A";
        for (int i = 0; i < 4; i++) step();
        rx_valid = 1'b0;
        n_total++;
        if ({tx_valid, busy, miss_cnt, last_letter} !== {2'b00, 4'(MM), 8'h56}) begin
            $display("FAIL lose_ignore: txv=%b busy=%b miss=%0d last=%h required 0 0 %0d 56",
                     tx_valid, busy, miss_cnt, last_letter, MM);
        end else n_pass++;
    endtask

    task automatic test_win();
        logic [7:0] v;
        int         lat;
        string      gs;
        gs = "APLE";
        new_game(pack_word("APPLE"));
        for (int i = 0; i < 4; i++) do_guess(gs[i], v, lat);
        n_total++;
        if (v !== "W") $display("FAIL win_verdict: got %h required %h", v, 8'h57);
        else n_pass++;
        n_total++;
        if ({won, lost, rx_ready, hit_mask} !== {3'b100, 5'b11111}) begin
            $display("FAIL win_state: won/lost/rdy=%b mask=%b required 100 11111",
                     {won, lost, rx_ready}, hit_mask);
        end else n_pass++;
    endtask

    task automatic test_dup();
        logic [7:0] v;
        int         lat;
        new_game(pack_word("APPLE"));
`ifdef HANGMAN_DUP_DETECT_EN
        do_guess("P", v, lat);
        do_guess("P", v, lat);
        n_total++;
        if (v !== "D") $display("FAIL dup_verdict: got %h required %h", v, 8'h44);
        else n_pass++;
        n_total++;
        if ({hit_mask, miss_cnt} !== {5'b00110, 4'd0}) begin
            $display("FAIL dup_state: mask=%b miss=%0d required 00110 0", hit_mask, miss_cnt);
        end else n_pass++;
`else
        do_guess("Z", v, lat);
        do_guess("Z", v, lat);
        n_total++;
        if (v !== "M") $display("FAIL dup_verdict: got %h required %h", v, 8'h4D);
        else n_pass++;
        n_total++;
        if (miss_cnt !== 4'd2) $display("FAIL dup_miss: got %0d required 2", miss_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_invalid();
        logic [7:0] v;
        int         lat;
        new_game(pack_word("APPLE"));
        do_guess("5", v, lat);
        n_total++;
        if (v !== "X") $display("FAIL inv_verdict: got %h required %h", v, 8'h58);
        else n_pass++;
        n_total++;
        if (lat !== 1) $display("FAIL inv_latency: got %0d required 1", lat);
        else n_pass++;
        n_total++;
        if (miss_cnt !== 4'd0) $display("FAIL inv_miss: got %0d required 0", miss_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        bit         stable;
        int         n;
        new_game(pack_word("APPLE"));
        rx_valid = 1'b1;
        rx_byte  = "e";
        step();
        rx_valid = 1'b0;
        n = 0;
        while (!tx_valid && n < 50) begin
            step();
            n++;
        end
        held   = tx_byte;
        stable = tx_valid;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!tx_valid || tx_byte !== held) stable = 1'b0;
        end
        n_total++;
        if (!stable || held !== "H") begin
            $display("FAIL bp_hold: stable=%b byte=%h required 1 %h", stable, held, 8'h48);
        end else n_pass++;
        n_total++;
        if (hit_mask !== 5'b10000) $display("FAIL bp_mask: got %b required 10000", hit_mask);
        else n_pass++;
        start = 1'b1;
        step();
        start = 1'b0;
        n_total++;
        if ({tx_valid, busy, rx_ready, miss_cnt, hit_mask} !== {3'b001, 4'd0, 5'b0}) begin
            $display("FAIL bp_restart: txv/busy/rdy=%b miss=%0d mask=%b required 001 0 00000",
                     {tx_valid, busy, rx_ready}, miss_cnt, hit_mask);
        end else n_pass++;
    endtask

    task automatic test_random_games();
        logic [8*WL-1:0] w;
        logic [7:0]      c;
        logic [7:0]      v;
        logic [7:0]      ev;
        int              lat;
        for (int g = 0; g < 6; g++) begin
            for (int i = 0; i < WL; i++) begin
                c = 8'h41 + 8'($urandom_range(0, 9));
                if ($urandom_range(0, 1) == 1) c = c + 8'h20;
                w[8*i +: 8] = c;
            end
            new_game(w);
            for (int k = 0; k < 40 && !m_won && !m_lost; k++) begin
                if ($urandom_range(0, 9) == 0) c = 8'h30 + 8'($urandom_range(0, 9));
                else c = 8'h41 + 8'($urandom_range(0, 12));
                if ($urandom_range(0, 1) == 1 && c >= 8'h41) c = c + 8'h20;
                do_guess(c, v, lat);
                model_guess(c, ev);
                n_total++;
                if (v !== ev) $display("FAIL rnd_verdict g%0d k%0d: got %h required %h", g, k, v, ev);
                else n_pass++;
                n_total++;
                if (lat !== ((ev == "X") ? 1 : WL + 1)) begin
                    $display("FAIL rnd_latency g%0d k%0d: got %0d", g, k, lat);
                end else n_pass++;
                n_total++;
                if ({hit_mask, miss_cnt, last_letter} !== {m_mask(), 4'(m_miss), m_last}) begin
                    $display("FAIL rnd_state g%0d k%0d: mask=%b miss=%0d last=%h required %b %0d %h",
                             g, k, hit_mask, miss_cnt, last_letter, m_mask(), m_miss, m_last);
                end else n_pass++;
            end
            n_total++;
            if ({won, lost} !== {m_won, m_lost}) begin
                $display("FAIL rnd_outcome g%0d: won/lost=%b%b required %b%b",
                         g, won, lost, m_won, m_lost);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_lose();
        test_win();
        test_dup();
        test_invalid();
        test_backpressure();
        test_random_games();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
